// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// reg_file_sb : parametrised register file, 1-cycle registered reads,
//               hardwired-zero r0, per-register pending scoreboard.
//               Optional same-edge write forwarding: `define REGFILE_BYPASS_EN
// Revision    : 1.0
// ============================================================================
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   regWrite,
  input  logic [AW-1:0]          a3,
  input  logic [XLEN-1:0]        wd3,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   ra,
  output logic [NUM_RD*XLEN-1:0] rd,
  output logic [NUM_RD-1:0]      rd_pend,
  input  logic                   pend_set,
  input  logic [AW-1:0]          pend_addr
);

  // Register 0 has no storage: it always reads 0 and is never pending.
  logic [XLEN-1:0]        regs_q [1:NREGS-1];
  logic [XLEN-1:0]        regs_d [1:NREGS-1];
  logic [NREGS-1:1]       pend_q, pend_d;
  logic [NUM_RD*XLEN-1:0] rd_q, rd_d;
  logic [NUM_RD-1:0]      rd_pend_q, rd_pend_d;

  logic a3_in_range;
  logic pa_in_range;
  logic wr_valid;
  logic set_valid;

  if (NREGS == (1 << AW)) begin : g_full_range
    assign a3_in_range = 1'b1;
    assign pa_in_range = 1'b1;
  end else begin : g_part_range
    assign a3_in_range = (a3 < AW'(NREGS));
    assign pa_in_range = (pend_addr < AW'(NREGS));
  end

  assign wr_valid  = regWrite && (a3 != '0) && a3_in_range;
  assign set_valid = pend_set && (pend_addr != '0) && pa_in_range;

  // Clear-on-write is applied before set so a newly issued producer wins.
  always_comb begin : write_path
    regs_d = regs_q;
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      if (wr_valid && (a3 == AW'(r))) begin
        regs_d[r] = wd3;
        pend_d[r] = 1'b0;
      end
      if (set_valid && (pend_addr == AW'(r))) begin
        pend_d[r] = 1'b1;
      end
    end
  end

  always_comb begin : read_path
    rd_d      = rd_q;
    rd_pend_d = rd_pend_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        // Unmatched addresses (r0 or beyond NREGS) fall through to zero.
        rd_d[i*XLEN +: XLEN] = '0;
        rd_pend_d[i]         = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
          if (ra[i*AW +: AW] == AW'(r)) begin
            rd_d[i*XLEN +: XLEN] = regs_q[r];
            rd_pend_d[i]         = pend_q[r];
          end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (ra[i*AW +: AW] == a3)) begin
          rd_d[i*XLEN +: XLEN] = wd3;
          rd_pend_d[i]         = set_valid && (pend_addr == a3);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q    <= '0;
      rd_q      <= '0;
      rd_pend_q <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q    <= pend_d;
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rd      = rd_q;
  assign rd_pend = rd_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// tb_reg_file_sb : directed + randomized self-checking bench for reg_file_sb
// Revision       : 1.0
// ============================================================================
module tb_reg_file_sb;

  localparam int XLEN   = 32;
  localparam int NREGS  = 24;
  localparam int NUM_RD = 2;
  localparam int AW     = $clog2(NREGS);

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] C_COLLIDE = 32'h2;
`else
  localparam logic [31:0] C_COLLIDE = 32'h1;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   regWrite;
  logic [AW-1:0]          a3;
  logic [XLEN-1:0]        wd3;
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   ra;
  logic [NUM_RD*XLEN-1:0] rd;
  logic [NUM_RD-1:0]      rd_pend;
  logic                   pend_set;
  logic [AW-1:0]          pend_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: plain arrays indexed by register number.
  logic [31:0] m_regs [NREGS];
  logic        m_pend [NREGS];
  logic [31:0] m_rd   [NUM_RD];
  logic        m_rdp  [NUM_RD];

  reg_file_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NUM_RD(NUM_RD)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .regWrite (regWrite),
    .a3       (a3),
    .wd3      (wd3),
    .rd_en    (rd_en),
    .ra       (ra),
    .rd       (rd),
    .rd_pend  (rd_pend),
    .pend_set (pend_set),
    .pend_addr(pend_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model by the architectural rules, compare.
  task automatic tk(input int t_rst, input int t_we, input int t_a3, input logic [31:0] t_wd,
                    input int t_en, input int t_ra0, input int t_ra1, input int t_ps, input int t_pa);
    logic [31:0] n_regs [NREGS];
    logic        n_pend [NREGS];
    int          addr [NUM_RD];
    bit          wr_ok;
    rst       = 1'(t_rst);
    regWrite  = 1'(t_we);
    a3        = AW'(t_a3);
    wd3       = t_wd;
    rd_en     = NUM_RD'(t_en);
    ra        = {AW'(t_ra1), AW'(t_ra0)};
    pend_set  = 1'(t_ps);
    pend_addr = AW'(t_pa);
    addr[0]   = t_ra0 % (1 << AW);
    addr[1]   = t_ra1 % (1 << AW);
    n_regs    = m_regs;
    n_pend    = m_pend;
    wr_ok     = (t_we != 0) && (t_a3 != 0) && (t_a3 < NREGS);
    if (t_rst != 0) begin
      for (int r = 0; r < NREGS; r++) begin
        n_regs[r] = '0;
        n_pend[r] = 1'b0;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        m_rd[p]  = '0;
        m_rdp[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (((t_en >> p) & 1) != 0) begin
          if (addr[p] < NREGS) begin
            m_rd[p]  = m_regs[addr[p]];
            m_rdp[p] = m_pend[addr[p]];
          end else begin
            m_rd[p]  = '0;
            m_rdp[p] = 1'b0;
          end
`ifdef REGFILE_BYPASS_EN
          if (wr_ok && addr[p] == t_a3) begin
            m_rd[p]  = t_wd;
            m_rdp[p] = (t_ps != 0) && (t_pa == t_a3);
          end
`endif
        end
      end
      if (wr_ok) begin
        n_regs[t_a3] = t_wd;
        n_pend[t_a3] = 1'b0;
      end
      if ((t_ps != 0) && (t_pa != 0) && (t_pa < NREGS)) begin
        n_pend[t_pa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_regs = n_regs;
    m_pend = n_pend;
    chk("rd0",   64'(rd[31:0]),  64'(m_rd[0]));
    chk("rd1",   64'(rd[63:32]), 64'(m_rd[1]));
    chk("pend0", 64'(rd_pend[0]), 64'(m_rdp[0]));
    chk("pend1", 64'(rd_pend[1]), 64'(m_rdp[1]));
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, (1 << AW) - 1));
    return int'($urandom_range(0, 9));
  endfunction

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      m_rd[p]  = '0;
      m_rdp[p] = 1'b0;
    end

    tk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_rd", 64'(rd), 64'd0);
    chk("reset_pend", 64'(rd_pend), 64'd0);

    // Random writes and pend marks, then reset and sweep every register.
    for (int c = 0; c < 20; c++) begin
      tk(0, 1, int'($urandom_range(1, NREGS - 1)), $urandom, 0, 0, 0, 1, int'($urandom_range(1, NREGS - 1)));
    end
    tk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < NREGS; r += 2) begin
      tk(0, 0, 0, 0, 3, r, r + 1, 0, 0);
      chk("sweep_rd", 64'(rd), 64'd0);
      chk("sweep_pend", 64'(rd_pend), 64'd0);
    end

    tk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("wr5_rd0", 64'(rd[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("wr5_pend0", 64'(rd_pend[0]), 64'd0);

    tk(0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("r0_both", 64'(rd), 64'd0);

    tk(0, 1, 7, 32'h1, 0, 0, 0, 0, 0);
    tk(0, 1, 7, 32'h2, 1, 7, 0, 0, 0);
    chk("collide_rd0", 64'(rd[31:0]), 64'(C_COLLIDE));
    tk(0, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("after_collide", 64'(rd[31:0]), 64'h2);

    tk(0, 0, 0, 0, 0, 0, 0, 1, 9);
    tk(0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("pend9_set", 64'(rd_pend[0]), 64'd1);
    tk(0, 1, 9, 32'hAB, 0, 0, 0, 1, 9);
    tk(0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("pend9_setwins", 64'(rd_pend[0]), 64'd1);
    tk(0, 1, 9, 32'hCD, 0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("pend9_clear", 64'(rd_pend[0]), 64'd0);
    chk("pend9_data", 64'(rd[31:0]), 64'hCD);

    tk(0, 0, 0, 0, 1, 5, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tk(0, 0, 0, 0, 0, c + 1, 0, 0, 0);
      chk("hold_rd0", 64'(rd[31:0]), 64'h0000_0000_DEAD_BEEF);
    end

    tk(0, 1, 3, 32'hAA, 0, 0, 0, 0, 0);
    tk(1, 1, 3, 32'hBB, 3, 3, 3, 1, 4);
    tk(0, 0, 0, 0, 3, 3, 4, 0, 0);
    chk("rst_mid_rd", 64'(rd), 64'd0);
    chk("rst_mid_pend", 64'(rd_pend), 64'd0);

    tk(0, 1, 30, 32'h55, 0, 0, 0, 1, 30);
    tk(0, 0, 0, 0, 3, 30, 23, 0, 0);

    for (int c = 0; c < 600; c++) begin
      tk(($urandom_range(0, 59) == 0) ? 1 : 0, int'($urandom_range(0, 1)), rand_addr(), $urandom,
         int'($urandom_range(0, 3)), rand_addr(), rand_addr(), int'($urandom_range(0, 1)), rand_addr());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
